// File: rtl/ctrl_pkg.sv
// Shared control-bundle types for the ID->EX->MEM->WB control pipeline.
package ctrl_pkg;

    typedef struct packed {
        logic       alusrc;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dest;
        logic       mem_read;
        logic       mem_write;
        logic       isbranchtaken;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_bundle_t;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    // Later stages only keep the controls they still consume.
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    function automatic mem_ctrl_t to_mem_ctrl(input ctrl_bundle_t c);
        mem_ctrl_t m;
        m.mem_read   = c.mem_read;
        m.mem_write  = c.mem_write;
        m.reg_write  = c.reg_write;
        m.mem_to_reg = c.mem_to_reg;
        return m;
    endfunction

    function automatic wb_ctrl_t to_wb_ctrl(input mem_ctrl_t m);
        wb_ctrl_t w;
        w.reg_write  = m.reg_write;
        w.mem_to_reg = m.mem_to_reg;
        return w;
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// Generic pipeline register: flush clears to a bubble, load captures, otherwise holds.
module ctrl_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    input  logic         load,
    input  logic         flush,
    output logic [W-1:0] q
);

    // Stage storage; flush has priority over load.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: carries decoder controls ID->EX->MEM->WB with load-use stall and branch squash.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16,
    parameter bit HAZARD_EN  = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    output logic                  id_ready_o,
    input  logic                  id_alusrc_i,
    input  logic                  id_mem_to_reg_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_reg_dest_i,
    input  logic                  id_mem_read_i,
    input  logic                  id_mem_write_i,
    input  logic                  id_isbranchtaken_i,
    input  logic                  id_jump_i,
    input  logic [1:0]            id_alu_op_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  mem_stall_i,
    output logic                  ex_valid_o,
    output logic                  ex_alusrc_o,
    output logic                  ex_reg_dest_o,
    output logic [1:0]            ex_alu_op_o,
    output logic [REG_ADDR_W-1:0] ex_rd_o,
    output logic                  mem_valid_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [REG_ADDR_W-1:0] mem_rd_o,
    output logic                  wb_valid_o,
    output logic                  wb_reg_write_o,
    output logic                  wb_mem_to_reg_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic                  redirect_o,
    output logic [CNT_W-1:0]      bubble_cnt_o
);

    localparam int EX_W  = 1 + REG_ADDR_W + $bits(ctrl_bundle_t);
    localparam int MEM_W = 1 + REG_ADDR_W + $bits(mem_ctrl_t);
    localparam int WB_W  = 1 + REG_ADDR_W + $bits(wb_ctrl_t);

    ctrl_bundle_t          id_ctrl;
    ctrl_bundle_t          ex_ctrl;
    mem_ctrl_t             mem_ctrl;
    wb_ctrl_t              wb_ctrl;
    logic                  ex_valid, mem_valid, wb_valid;
    logic [REG_ADDR_W-1:0] ex_rd, mem_rd, wb_rd;
    logic [EX_W-1:0]       ex_q;
    logic [MEM_W-1:0]      mem_q;
    logic [WB_W-1:0]       wb_q;
    logic                  advance, redirect, hazard, squash, bubble_inc;
    logic [CNT_W-1:0]      bubble_cnt;

    assign id_ctrl = '{alusrc: id_alusrc_i, mem_to_reg: id_mem_to_reg_i,
                       reg_write: id_reg_write_i, reg_dest: id_reg_dest_i,
                       mem_read: id_mem_read_i, mem_write: id_mem_write_i,
                       isbranchtaken: id_isbranchtaken_i, jump: id_jump_i,
                       alu_op: id_alu_op_i};

    assign {ex_valid, ex_rd, ex_ctrl}    = ex_q;
    assign {mem_valid, mem_rd, mem_ctrl} = mem_q;
    assign {wb_valid, wb_rd, wb_ctrl}    = wb_q;

    assign advance  = ~mem_stall_i;
    assign redirect = ex_valid & (ex_ctrl.isbranchtaken | ex_ctrl.jump);

    // Load-use detection against the instruction waiting in decode; x0 never hazards.
    always_comb begin
        hazard = 1'b0;
        if (HAZARD_EN && ex_valid && ex_ctrl.mem_read && (ex_rd != '0) && id_valid_i &&
            ((ex_rd == id_rs1_i) || (ex_rd == id_rs2_i))) begin
            hazard = 1'b1;
        end else begin
            hazard = 1'b0;
        end
    end

    // Decode handshake in priority order reset > stall > redirect > load-use > advance.
    always_comb begin
        id_ready_o = 1'b0;
        if (rst_i) begin
            id_ready_o = 1'b0;
        end else if (mem_stall_i) begin
            id_ready_o = 1'b0;
        end else if (redirect) begin
            id_ready_o = id_valid_i;
        end else begin
            id_ready_o = ~hazard;
        end
    end

    assign squash     = redirect | hazard | ~id_valid_i;
    assign bubble_inc = advance & (redirect ? id_valid_i : hazard);

    ctrl_stage_reg #(.W(EX_W)) u_ex (
        .clk(clk_i), .rst(rst_i),
        .d({1'b1, id_rd_i, id_ctrl}),
        .load(advance), .flush(advance & squash),
        .q(ex_q)
    );

    ctrl_stage_reg #(.W(MEM_W)) u_mem (
        .clk(clk_i), .rst(rst_i),
        .d({ex_valid, ex_rd, to_mem_ctrl(ex_ctrl)}),
        .load(advance), .flush(1'b0),
        .q(mem_q)
    );

    ctrl_stage_reg #(.W(WB_W)) u_wb (
        .clk(clk_i), .rst(rst_i),
        .d({mem_valid, mem_rd, to_wb_ctrl(mem_ctrl)}),
        .load(advance), .flush(1'b0),
        .q(wb_q)
    );

    // Saturating count of inserted bubbles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bubble_cnt <= '0;
        end else if (bubble_inc && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            bubble_cnt <= bubble_cnt;
        end
    end

    assign ex_valid_o      = ex_valid;
    assign ex_alusrc_o     = ex_ctrl.alusrc;
    assign ex_reg_dest_o   = ex_ctrl.reg_dest;
    assign ex_alu_op_o     = ex_ctrl.alu_op;
    assign ex_rd_o         = ex_rd;
    assign mem_valid_o     = mem_valid;
    assign mem_read_o      = mem_ctrl.mem_read;
    assign mem_write_o     = mem_ctrl.mem_write;
    assign mem_rd_o        = mem_rd;
    assign wb_valid_o      = wb_valid;
    assign wb_reg_write_o  = wb_ctrl.reg_write;
    assign wb_mem_to_reg_o = wb_ctrl.mem_to_reg;
    assign wb_rd_o         = wb_rd;
    assign redirect_o      = redirect;
    assign bubble_cnt_o    = bubble_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus randomized traffic against an instruction-level model.
module tb_ctrl_pipe;
    import ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         id_valid = 1'b0;
    logic         mem_stall = 1'b0;
    ctrl_bundle_t id_c = '0;
    logic [4:0]   rs1 = '0, rs2 = '0, rd = '0;

    logic id_ready, ex_valid, ex_alusrc, ex_reg_dest, mem_valid, mem_read, mem_write;
    logic wb_valid, wb_reg_write, wb_mem_to_reg, redirect;
    logic [1:0] ex_alu_op;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic [15:0] bubble_cnt;

    logic s_id_ready, s_ex_valid, s_ex_alusrc, s_ex_reg_dest, s_mem_valid, s_mem_read, s_mem_write;
    logic s_wb_valid, s_wb_reg_write, s_wb_mem_to_reg, s_redirect;
    logic [1:0] s_ex_alu_op;
    logic [4:0] s_ex_rd, s_mem_rd, s_wb_rd;
    logic [3:0] s_bubble_cnt;

    ctrl_pipe dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_ready_o(id_ready),
        .id_alusrc_i(id_c.alusrc), .id_mem_to_reg_i(id_c.mem_to_reg), .id_reg_write_i(id_c.reg_write),
        .id_reg_dest_i(id_c.reg_dest), .id_mem_read_i(id_c.mem_read), .id_mem_write_i(id_c.mem_write),
        .id_isbranchtaken_i(id_c.isbranchtaken), .id_jump_i(id_c.jump), .id_alu_op_i(id_c.alu_op),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd), .mem_stall_i(mem_stall),
        .ex_valid_o(ex_valid), .ex_alusrc_o(ex_alusrc), .ex_reg_dest_o(ex_reg_dest),
        .ex_alu_op_o(ex_alu_op), .ex_rd_o(ex_rd), .mem_valid_o(mem_valid), .mem_read_o(mem_read),
        .mem_write_o(mem_write), .mem_rd_o(mem_rd), .wb_valid_o(wb_valid), .wb_reg_write_o(wb_reg_write),
        .wb_mem_to_reg_o(wb_mem_to_reg), .wb_rd_o(wb_rd), .redirect_o(redirect), .bubble_cnt_o(bubble_cnt)
    );

    ctrl_pipe #(.CNT_W(4)) dut_small (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_ready_o(s_id_ready),
        .id_alusrc_i(id_c.alusrc), .id_mem_to_reg_i(id_c.mem_to_reg), .id_reg_write_i(id_c.reg_write),
        .id_reg_dest_i(id_c.reg_dest), .id_mem_read_i(id_c.mem_read), .id_mem_write_i(id_c.mem_write),
        .id_isbranchtaken_i(id_c.isbranchtaken), .id_jump_i(id_c.jump), .id_alu_op_i(id_c.alu_op),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd), .mem_stall_i(mem_stall),
        .ex_valid_o(s_ex_valid), .ex_alusrc_o(s_ex_alusrc), .ex_reg_dest_o(s_ex_reg_dest),
        .ex_alu_op_o(s_ex_alu_op), .ex_rd_o(s_ex_rd), .mem_valid_o(s_mem_valid), .mem_read_o(s_mem_read),
        .mem_write_o(s_mem_write), .mem_rd_o(s_mem_rd), .wb_valid_o(s_wb_valid), .wb_reg_write_o(s_wb_reg_write),
        .wb_mem_to_reg_o(s_wb_mem_to_reg), .wb_rd_o(s_wb_rd), .redirect_o(s_redirect), .bubble_cnt_o(s_bubble_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: which instruction occupies each stage, plus bubble tallies.
    typedef struct packed {
        logic         v;
        ctrl_bundle_t c;
        logic [4:0]   rd;
    } slot_t;

    slot_t       m_ex = '0, m_mem = '0, m_wb = '0;
    int unsigned m_cnt = 0, m_cnt_s = 0;

    typedef logic [25:0] obs_t;

    function automatic bit m_redirect();
        return m_ex.v && (m_ex.c.isbranchtaken || m_ex.c.jump);
    endfunction

    function automatic bit m_hazard();
        return m_ex.v && m_ex.c.mem_read && (m_ex.rd != 5'd0) && id_valid &&
               ((m_ex.rd == rs1) || (m_ex.rd == rs2));
    endfunction

    function automatic bit m_ready();
        if (rst || mem_stall) return 1'b0;
        if (m_redirect()) return id_valid;
        return !m_hazard();
    endfunction

    task automatic model_edge();
        bit kill, count;
        if (rst) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0; m_cnt_s = 0;
        end else if (!mem_stall) begin
            kill  = m_redirect() || m_hazard() || !id_valid;
            count = m_redirect() ? id_valid : m_hazard();
            if (count && m_cnt < 65535) m_cnt++;
            if (count && m_cnt_s < 15) m_cnt_s++;
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = kill ? slot_t'('0) : slot_t'{1'b1, id_c, rd};
        end
    endtask

    function automatic obs_t model_obs();
        return {m_ex.v, m_ex.c.alusrc, m_ex.c.reg_dest, m_ex.c.alu_op, m_ex.rd,
                m_mem.v, m_mem.c.mem_read, m_mem.c.mem_write, m_mem.rd,
                m_wb.v, m_wb.c.reg_write, m_wb.c.mem_to_reg, m_wb.rd};
    endfunction

    function automatic obs_t dut_obs();
        return {ex_valid, ex_alusrc, ex_reg_dest, ex_alu_op, ex_rd, mem_valid, mem_read, mem_write,
                mem_rd, wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd};
    endfunction

    function automatic obs_t small_obs();
        return {s_ex_valid, s_ex_alusrc, s_ex_reg_dest, s_ex_alu_op, s_ex_rd, s_mem_valid, s_mem_read,
                s_mem_write, s_mem_rd, s_wb_valid, s_wb_reg_write, s_wb_mem_to_reg, s_wb_rd};
    endfunction

    function automatic ctrl_bundle_t add_c();
        ctrl_bundle_t c = '0;
        c.reg_write = 1'b1; c.reg_dest = 1'b1; c.alu_op = ALU_OP_RTYPE;
        return c;
    endfunction

    function automatic ctrl_bundle_t lw_c();
        ctrl_bundle_t c = '0;
        c.alusrc = 1'b1; c.mem_read = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_OP_ADD;
        return c;
    endfunction

    function automatic ctrl_bundle_t sw_c();
        ctrl_bundle_t c = '0;
        c.alusrc = 1'b1; c.mem_write = 1'b1; c.alu_op = ALU_OP_ADD;
        return c;
    endfunction

    function automatic ctrl_bundle_t beq_c();
        ctrl_bundle_t c = '0;
        c.isbranchtaken = 1'b1; c.alu_op = ALU_OP_BRANCH;
        return c;
    endfunction

    function automatic ctrl_bundle_t jmp_c();
        ctrl_bundle_t c = '0;
        c.jump = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_OP_ITYPE;
        return c;
    endfunction

    task automatic present(input ctrl_bundle_t c, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        id_valid = 1'b1; id_c = c; rs1 = a; rs2 = b; rd = d;
    endtask

    task automatic idle();
        id_valid = 1'b0; id_c = '0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    endtask

    // Advance one clock; outputs are settled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_stall = 1'b0; idle();
        #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", id_ready); end
        tick(); tick();
        checks++; if (dut_obs() !== '0) begin errors++; $display("FAIL reset_stages: got %h want 0", dut_obs()); end
        checks++; if (redirect !== 1'b0 || bubble_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_misc: redirect %b cnt %0d want 0 0", redirect, bubble_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_straight();
        present(add_c(), 5'd1, 5'd2, 5'd3);
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL straight_ready0: got %b want 1", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd3 || ex_alu_op !== ALU_OP_RTYPE) begin
            errors++; $display("FAIL straight_ex: valid %b rd %0d op %b want 1 3 10", ex_valid, ex_rd, ex_alu_op); end
        idle(); #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL straight_ready1: got %b want 1", id_ready); end
        tick();
        checks++; if (mem_valid !== 1'b1 || mem_rd !== 5'd3) begin
            errors++; $display("FAIL straight_mem: valid %b rd %0d want 1 3", mem_valid, mem_rd); end
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_reg_write !== 1'b1) begin
            errors++; $display("FAIL straight_wb: valid %b rd %0d rw %b want 1 3 1", wb_valid, wb_rd, wb_reg_write); end
        drain();
    endtask

    task automatic test_load_use();
        logic [15:0] c0 = bubble_cnt;
        present(lw_c(), 5'd1, 5'd0, 5'd4); tick();
        present(add_c(), 5'd4, 5'd2, 5'd8); #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_ready: got %b want 0", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0 || mem_valid !== 1'b1 || mem_read !== 1'b1 || bubble_cnt !== c0 + 16'd1) begin
            errors++; $display("FAIL lu_bubble: ex_v %b mem_v %b mem_rd %b cnt %0d want 0 1 1 %0d",
                                ex_valid, mem_valid, mem_read, bubble_cnt, c0 + 16'd1); end
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_resume_ready: got %b want 1", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd8) begin
            errors++; $display("FAIL lu_late_ex: valid %b rd %0d want 1 8", ex_valid, ex_rd); end
        present(lw_c(), 5'd1, 5'd0, 5'd0); tick();
        present(add_c(), 5'd0, 5'd0, 5'd10); #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lu_x0_ready: got %b want 1", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd10 || bubble_cnt !== c0 + 16'd1) begin
            errors++; $display("FAIL lu_x0: valid %b rd %0d cnt %0d want 1 10 %0d", ex_valid, ex_rd, bubble_cnt, c0 + 16'd1); end
        drain();
    endtask

    task automatic test_branch();
        logic [15:0] c0 = bubble_cnt;
        present(beq_c(), 5'd1, 5'd2, 5'd0); tick();
        present(add_c(), 5'd1, 5'd2, 5'd9); #1;
        checks++; if (redirect !== 1'b1 || id_ready !== 1'b1) begin
            errors++; $display("FAIL br_redirect: redirect %b ready %b want 1 1", redirect, id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0 || mem_valid !== 1'b1 || bubble_cnt !== c0 + 16'd1) begin
            errors++; $display("FAIL br_squash: ex_v %b mem_v %b cnt %0d want 0 1 %0d", ex_valid, mem_valid, bubble_cnt, c0 + 16'd1); end
        idle(); #1;
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL br_one_cycle: redirect %b want 0", redirect); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (wb_valid === 1'b1 && wb_rd === 5'd9) begin
                errors++; $display("FAIL br_leak: squashed rd 9 reached WB at step %0d", i); end
        end
    endtask

    task automatic test_stall();
        logic [15:0] c0 = bubble_cnt;
        obs_t snap;
        present(lw_c(), 5'd1, 5'd0, 5'd4); tick();
        present(add_c(), 5'd6, 5'd4, 5'd11); mem_stall = 1'b1; #1;
        snap = dut_obs();
        for (int i = 0; i < 3; i++) begin
            checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b want 0", i, id_ready); end
            tick();
            checks++; if (dut_obs() !== snap || bubble_cnt !== c0) begin
                errors++; $display("FAIL stall_frozen%0d: got %h cnt %0d want %h cnt %0d", i, dut_obs(), bubble_cnt, snap, c0); end
        end
        mem_stall = 1'b0; #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_release_ready: got %b want 0", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0 || bubble_cnt !== c0 + 16'd1) begin
            errors++; $display("FAIL stall_release: ex_v %b cnt %0d want 0 %0d", ex_valid, bubble_cnt, c0 + 16'd1); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd11 || bubble_cnt !== c0 + 16'd1) begin
            errors++; $display("FAIL stall_after: ex_v %b rd %0d cnt %0d want 1 11 %0d", ex_valid, ex_rd, bubble_cnt, c0 + 16'd1); end
        drain();
    endtask

    task automatic test_reset_midflight();
        present(add_c(), 5'd1, 5'd2, 5'd5); tick();
        present(add_c(), 5'd1, 5'd2, 5'd6); tick();
        present(add_c(), 5'd1, 5'd2, 5'd7); rst = 1'b1; #1;
        checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0 || mem_valid !== 1'b0 || wb_valid !== 1'b0 || wb_reg_write !== 1'b0 ||
                      bubble_cnt !== 16'd0 || s_bubble_cnt !== 4'd0) begin
            errors++; $display("FAIL midrst_clear: v %b%b%b rw %b cnt %0d/%0d want 000 0 0/0",
                               ex_valid, mem_valid, wb_valid, wb_reg_write, bubble_cnt, s_bubble_cnt); end
        rst = 1'b0; idle();
    endtask

    task automatic test_saturation();
        present(jmp_c(), 5'd0, 5'd0, 5'd1);
        for (int i = 0; i < 40; i++) tick();
        checks++; if (s_bubble_cnt !== 4'd15) begin errors++; $display("FAIL sat_small: got %0d want 15", s_bubble_cnt); end
        checks++; if (bubble_cnt !== m_cnt[15:0] || bubble_cnt < 16'd18) begin
            errors++; $display("FAIL sat_wide: got %0d want %0d", bubble_cnt, m_cnt); end
        drain();
    endtask

    task automatic test_random();
        bit pending = 1'b0;
        int k;
        for (int i = 0; i < 400; i++) begin
            if (!pending) begin
                k = $urandom_range(9);
                present(k < 4 ? add_c() : k < 7 ? lw_c() : k == 7 ? sw_c() : k == 8 ? beq_c() : jmp_c(),
                        5'($urandom_range(5)), 5'($urandom_range(5)), 5'($urandom_range(5)));
                id_valid = ($urandom_range(4) != 0);
            end
            mem_stall = ($urandom_range(7) == 0);
            rst = ($urandom_range(63) == 0);
            #1;
            checks++; if (id_ready !== m_ready() || redirect !== m_redirect() ||
                          s_id_ready !== m_ready() || s_redirect !== m_redirect()) begin
                errors++; $display("FAIL rnd_comb%0d: ready %b/%b redirect %b/%b want %b %b",
                                   i, id_ready, s_id_ready, redirect, s_redirect, m_ready(), m_redirect()); end
            pending = id_valid && !m_ready() && !rst;
            tick();
            checks++; if (dut_obs() !== model_obs() || small_obs() !== model_obs()) begin
                errors++; $display("FAIL rnd_stage%0d: got %h/%h want %h", i, dut_obs(), small_obs(), model_obs()); end
            checks++; if (bubble_cnt !== m_cnt[15:0] || s_bubble_cnt !== m_cnt_s[3:0]) begin
                errors++; $display("FAIL rnd_cnt%0d: got %0d/%0d want %0d/%0d", i, bubble_cnt, s_bubble_cnt, m_cnt, m_cnt_s); end
        end
        rst = 1'b0; mem_stall = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_straight();
        test_load_use();
        test_branch();
        test_stall();
        test_reset_midflight();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
